// File: rtl/serial_uart_cfg_pkg.sv
// Shared parity codes, FSM state encodings and the parity helper for serial_uart_cfg.
package serial_uart_cfg_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_HUNT, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAITHI
   } rx_state_t;

   // Parity over the low nbits of d; zero when parity is disabled.
   function automatic logic calc_parity(input logic [7:0] d, input int nbits, input int mode);
      logic p;
      p = 1'b0;
      for (int i = 0; i < 8; i++)
         if (i < nbits) p = p ^ d[i];
      return (mode == PAR_ODD) ? ~p : (mode == PAR_EVEN) ? p : 1'b0;
   endfunction
endpackage

// File: rtl/serial_uart_fifo.sv
// Small synchronous FIFO with show-ahead read data; full/empty from extra pointer MSB.
module serial_uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr, r_rd_ptr;
   logic             w_wr, w_rd;

   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign w_wr    = wr_en && !full;
   assign w_rd    = rd_en && !empty;
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end
endmodule

// File: rtl/serial_uart_cfg.sv
// UART with runtime baud divisor, 5-8 data bits, optional parity, 1/2 stop bits,
// a TX FIFO and RX framing/parity error reporting.
module serial_uart_cfg
   import serial_uart_cfg_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int TX_DEPTH  = 4,
   parameter int DIV_BITS  = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [DIV_BITS-1:0] baud_div,
   input  logic                serial_in,
   output logic                serial_out,
   input  logic [7:0]          as_data_i,
   input  logic                as_dstrb_i,
   output logic                as_busy_o,
   output logic [7:0]          as_data_o,
   output logic                as_dstrb_o,
   output logic                as_ferr_o,
   output logic                as_perr_o
);
   localparam logic [DIV_BITS-1:0] DIV_ONE   = DIV_BITS'(1);
   localparam logic [2:0]          LAST_DBIT = 3'(DATA_BITS-1);
   localparam logic [2:0]          LAST_SBIT = 3'(STOP_BITS-1);
   localparam logic [7:0]          DMASK     = 8'((1 << DATA_BITS) - 1);
   localparam bit                  HAS_PAR   = (PARITY != PAR_NONE);

   tx_state_t           r_tx_state;
   logic [DIV_BITS-1:0] r_tx_cnt, r_tx_div;
   logic [2:0]          r_tx_bit;
   logic [7:0]          r_tx_shift;
   logic                r_tx_par;
   logic [7:0]          w_fifo_data;
   logic                w_fifo_full, w_fifo_empty, w_tx_bit_end, w_tx_last_stop, w_tx_pop;

   assign w_tx_bit_end   = (r_tx_cnt == r_tx_div - DIV_ONE);
   assign w_tx_last_stop = (r_tx_state == TX_STOP) && w_tx_bit_end && (r_tx_bit == LAST_SBIT);
   assign w_tx_pop       = !w_fifo_empty && ((r_tx_state == TX_IDLE) || w_tx_last_stop);
   assign as_busy_o      = w_fifo_full;

   serial_uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (as_dstrb_i),
      .wr_data (as_data_i),
      .rd_en   (w_tx_pop),
      .rd_data (w_fifo_data),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty)
   );

   // serial_out is registered from the current state, so the line lags the state by one clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tx_state <= TX_IDLE;
         r_tx_cnt   <= '0;
         r_tx_div   <= '0;
         r_tx_bit   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
         serial_out <= 1'b1;
      end else begin
         case (r_tx_state)
            TX_START:  serial_out <= 1'b0;
            TX_DATA:   serial_out <= r_tx_shift[0];
            TX_PARITY: serial_out <= r_tx_par;
            default:   serial_out <= 1'b1;
         endcase
         r_tx_cnt <= w_tx_bit_end ? '0 : r_tx_cnt + DIV_ONE;
         if (w_tx_pop) begin
            r_tx_state <= TX_START;
            r_tx_cnt   <= '0;
            r_tx_div   <= baud_div;
            r_tx_shift <= w_fifo_data & DMASK;
            r_tx_par   <= calc_parity(w_fifo_data, DATA_BITS, PARITY);
         end else if (w_tx_bit_end) begin
            r_tx_bit <= r_tx_bit + 3'd1;
            case (r_tx_state)
               TX_START: begin
                  r_tx_state <= TX_DATA;
                  r_tx_bit   <= '0;
               end
               TX_DATA: begin
                  r_tx_shift <= r_tx_shift >> 1;
                  if (r_tx_bit == LAST_DBIT) begin
                     r_tx_state <= HAS_PAR ? TX_PARITY : TX_STOP;
                     r_tx_bit   <= '0;
                  end
               end
               TX_PARITY: begin
                  r_tx_state <= TX_STOP;
                  r_tx_bit   <= '0;
               end
               TX_STOP: if (r_tx_bit == LAST_SBIT) r_tx_state <= TX_IDLE;
               default: ;
            endcase
         end
      end
   end

   rx_state_t           r_rx_state;
   logic                r_rx_meta, r_rx_sync, r_rx_par;
   logic [DIV_BITS-1:0] r_rx_cnt, r_rx_div;
   logic [2:0]          r_rx_bit;
   logic [7:0]          r_rx_data;
   logic                w_rx_bit_end, w_rx_half;

   assign w_rx_bit_end = (r_rx_cnt == r_rx_div - DIV_ONE);
   assign w_rx_half    = (r_rx_cnt == (r_rx_div >> 1) - DIV_ONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_state <= RX_HUNT;
         r_rx_cnt   <= '0;
         r_rx_div   <= '0;
         r_rx_bit   <= '0;
         r_rx_data  <= '0;
         r_rx_par   <= 1'b0;
         as_dstrb_o <= 1'b0;
         as_data_o  <= '0;
         as_ferr_o  <= 1'b0;
         as_perr_o  <= 1'b0;
      end else begin
         r_rx_meta  <= serial_in;
         r_rx_sync  <= r_rx_meta;
         as_dstrb_o <= 1'b0;
         r_rx_cnt   <= r_rx_cnt + DIV_ONE;
         case (r_rx_state)
            RX_HUNT: if (!r_rx_sync) begin
               r_rx_state <= RX_START;
               r_rx_div   <= baud_div;
               r_rx_cnt   <= '0;
               r_rx_data  <= '0;
            end
            RX_START: if (w_rx_half) begin
               r_rx_cnt   <= '0;
               r_rx_bit   <= '0;
               r_rx_state <= r_rx_sync ? RX_HUNT : RX_DATA;
            end
            RX_DATA: if (w_rx_bit_end) begin
               r_rx_cnt            <= '0;
               r_rx_data[r_rx_bit] <= r_rx_sync;
               r_rx_bit            <= r_rx_bit + 3'd1;
               if (r_rx_bit == LAST_DBIT) r_rx_state <= HAS_PAR ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (w_rx_bit_end) begin
               r_rx_cnt   <= '0;
               r_rx_par   <= r_rx_sync;
               r_rx_state <= RX_STOP;
            end
            // A low stop sample parks in WAITHI so a held break reports only once.
            RX_STOP: if (w_rx_bit_end) begin
               r_rx_cnt   <= '0;
               as_dstrb_o <= 1'b1;
               as_data_o  <= r_rx_data;
               as_ferr_o  <= !r_rx_sync;
               as_perr_o  <= HAS_PAR && (calc_parity(r_rx_data, DATA_BITS, PARITY) != r_rx_par);
               r_rx_state <= r_rx_sync ? RX_HUNT : RX_WAITHI;
            end
            RX_WAITHI: if (r_rx_sync) r_rx_state <= RX_HUNT;
            default: r_rx_state <= RX_HUNT;
         endcase
      end
   end
endmodule
